// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO sitting in front of a UART transmitter core.
// Register writes push bytes. A small FSM pops one byte at a time, pulses
// start_tx_o, holds tx_data_o, and waits for the core's tx_active_i to rise
// and fall before moving on to the next byte.
//
// Ports
//   clk             clock
//   reset_n         asynchronous reset, active low
//   sync_reset_i    synchronous flush of FIFO, FSM and flags
//   wr_en_i         push strobe for wr_data_i
//   wr_data_i       byte to queue
//   clr_overflow_i  clears the sticky overflow flag
//   tx_active_i     high while the UART core is shifting
//   start_tx_o      one-cycle start pulse to the UART core
//   tx_data_o       byte for the UART core, held from start until done
//   fifo_count_o    occupancy, 0..FIFO_DEPTH
//   fifo_full_o     fifo_count_o == FIFO_DEPTH
//   fifo_empty_o    fifo_count_o == 0
//   overflow_o      sticky, set when a push hits a full FIFO
//   busy_o          FIFO not empty or FSM not idle
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sync_reset_i,
    input  logic                        wr_en_i,
    input  logic [DATA_WIDTH-1:0]       wr_data_i,
    input  logic                        clr_overflow_i,
    input  logic                        tx_active_i,
    output logic                        start_tx_o,
    output logic [DATA_WIDTH-1:0]       tx_data_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        fifo_full_o,
    output logic                        fifo_empty_o,
    output logic                        overflow_o,
    output logic                        busy_o
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned TimerW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [CntW-1:0]   DepthCnt  = CntW'(FIFO_DEPTH);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitAct,
        StWaitDone
    } state_e;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;

    state_e                state_q;
    logic [TimerW-1:0]     timer_q;
    logic                  start_tx_q;
    logic [DATA_WIDTH-1:0] tx_data_q;

    logic full, empty, push, pop, drop;

    // Full is judged on the registered count, so a push into a full FIFO is
    // dropped even when the FSM pops in the same cycle.
    assign full  = (count_q == DepthCnt);
    assign empty = (count_q == '0);
    assign push  = wr_en_i & ~full & ~sync_reset_i;
    assign drop  = wr_en_i & full & ~sync_reset_i;
    // Must match the IDLE pop condition in the FSM below.
    assign pop   = (state_q == StIdle) & ~empty & ~sync_reset_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (sync_reset_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
            // Setting wins over clearing in the same cycle.
            if (drop) begin
                overflow_d = 1'b1;
            end else if (clr_overflow_i) begin
                overflow_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; the count says which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Handshake FSM with registered start pulse and data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            start_tx_q <= 1'b0;
            tx_data_q  <= '0;
        end else if (sync_reset_i) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            start_tx_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        tx_data_q  <= mem_q[rd_ptr_q];
                        start_tx_q <= 1'b1;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    start_tx_q <= 1'b0;
                    timer_q    <= '0;
                    state_q    <= StWaitAct;
                end
                StWaitAct: begin
                    // A byte whose start is never acknowledged is dropped, not retried.
                    if (tx_active_i) begin
                        state_q <= StWaitDone;
                    end else if (timer_q == TimerLast) begin
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                StWaitDone: begin
                    if (!tx_active_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign start_tx_o   = start_tx_q;
    assign tx_data_o    = tx_data_q;
    assign fifo_count_o = count_q;
    assign fifo_full_o  = full;
    assign fifo_empty_o = empty;
    assign overflow_o   = overflow_q;
    assign busy_o       = ~empty | (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset state, single byte latency, fill to
// full, overflow drop on full, acknowledge timeout, sync and async flush, and
// randomized bursts checked in order against a queue of pushed bytes.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sync_reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_overflow;
    logic       tx_active;
    logic       start_tx;
    logic [7:0] tx_data;
    logic [3:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;
    logic       busy;

    // tx_active comes either from the bench directly or from a UART model.
    logic       man_active;
    logic       model_active;
    logic       auto_uart;
    int         m_cnt;

    logic [7:0] seen[$];
    logic [7:0] expq[$];
    logic       prev_start;
    int         dbl_start;
    int         max_count;

    int n_checks;
    int n_pass;
    int n_fail;

    assign tx_active = auto_uart ? model_active : man_active;

    uart_tx_fifo #(
        .FIFO_DEPTH  (8),
        .DATA_WIDTH  (8),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sync_reset_i   (sync_reset),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .clr_overflow_i (clr_overflow),
        .tx_active_i    (tx_active),
        .start_tx_o     (start_tx),
        .tx_data_o      (tx_data),
        .fifo_count_o   (fifo_count),
        .fifo_full_o    (fifo_full),
        .fifo_empty_o   (fifo_empty),
        .overflow_o     (overflow),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    // UART model: raises tx_active in the start cycle and holds it a few cycles.
    always @(negedge clk) begin
        if (!auto_uart) begin
            model_active = 1'b0;
            m_cnt        = 0;
        end else if (m_cnt != 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                model_active = 1'b0;
            end
        end else if (start_tx) begin
            model_active = 1'b1;
            m_cnt        = 3;
        end
    end

    // Monitor: records every start pulse with its data.
    always @(negedge clk) begin
        if (start_tx === 1'b1) begin
            seen.push_back(tx_data);
            if (prev_start === 1'b1) begin
                dbl_start = dbl_start + 1;
            end
        end
        prev_start = start_tx;
        if (int'(fifo_count) > max_count) begin
            max_count = int'(fifo_count);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int guard;
        int len;
        int k;
        int gap;

        n_checks     = 0;
        n_pass       = 0;
        n_fail       = 0;
        dbl_start    = 0;
        max_count    = 0;
        prev_start   = 1'b0;
        reset_n      = 1'b0;
        sync_reset   = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        clr_overflow = 1'b0;
        man_active   = 1'b0;
        auto_uart    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_count", 32'(fifo_count), 0);
        check("rst_empty", 32'(fifo_empty), 1);
        check("rst_full", 32'(fifo_full), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_start", 32'(start_tx), 0);
        check("rst_txdata", 32'(tx_data), 0);
        check("rst_ovf", 32'(overflow), 0);
        reset_n = 1'b1;
        tick();

        // Test 1: single byte, start pulse two edges after the push
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        check("t1_count1", 32'(fifo_count), 1);
        check("t1_busy", 32'(busy), 1);
        check("t1_nostart", 32'(start_tx), 0);
        tick();
        check("t1_start", 32'(start_tx), 1);
        check("t1_data", 32'(tx_data), 32'h55);
        check("t1_count0", 32'(fifo_count), 0);
        tick();
        check("t1_pulse1", 32'(start_tx), 0);
        tick();
        man_active = 1'b1;
        repeat (6) tick();
        check("t1_hold_data", 32'(tx_data), 32'h55);
        check("t1_busy_act", 32'(busy), 1);
        man_active = 1'b0;
        tick();
        check("t1_busy_fall", 32'(busy), 0);

        // Test 2: stall FSM on a dummy byte, then fill to full
        wr_en   = 1'b1;
        wr_data = 8'h00;
        tick();
        wr_en = 1'b0;
        tick();
        man_active = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check("t2_full", 32'(fifo_full), 1);
        check("t2_count8", 32'(fifo_count), 8);
        check("t2_ovf0", 32'(overflow), 0);
        check("t2_notempty", 32'(fifo_empty), 0);

        // Test 3: push on full in the same cycle as a pop is dropped
        seen.delete();
        man_active = 1'b0;
        tick();
        check("t3_count_pre", 32'(fifo_count), 8);
        wr_en   = 1'b1;
        wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        check("t3_count7", 32'(fifo_count), 7);
        check("t3_ovf1", 32'(overflow), 1);
        check("t3_start", 32'(start_tx), 1);
        check("t3_data01", 32'(tx_data), 32'h01);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t3_ovf_clr", 32'(overflow), 0);

        // Drain the eight bytes through the UART model
        auto_uart = 1'b1;
        guard     = 0;
        while (busy && guard < 500) begin
            tick();
            guard++;
        end
        check("t2_drained", 32'(busy), 0);
        check("t2_nsent", 32'(seen.size()), 8);
        for (int i = 0; i < 8; i++) begin
            check("t2_order", 32'(seen[i]), i + 1);
        end
        check("t2_ovf_end", 32'(overflow), 0);
        auto_uart = 1'b0;
        tick();

        // Test 4: tx_active never rises; FSM times out and moves on
        wr_en   = 1'b1;
        wr_data = 8'h11;
        tick();
        wr_data = 8'h22;
        tick();
        wr_en = 1'b0;
        check("t4_start11", 32'(tx_data), 32'h11);
        repeat (5) tick();
        check("t4_still_wait", 32'(start_tx), 0);
        check("t4_count1", 32'(fifo_count), 1);
        tick();
        check("t4_start22", 32'(start_tx), 1);
        check("t4_data22", 32'(tx_data), 32'h22);
        repeat (4) tick();
        check("t4_busy_wait", 32'(busy), 1);
        tick();
        check("t4_idle", 32'(busy), 0);

        // Test 5: sync_reset with 5 bytes queued and FSM in WAIT_DONE
        wr_en   = 1'b1;
        wr_data = 8'h30;
        tick();
        man_active = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wr_data = 8'(8'h30 + i);
            tick();
        end
        wr_en = 1'b0;
        check("t5_count5", 32'(fifo_count), 5);
        check("t5_busy", 32'(busy), 1);
        check("t5_data30", 32'(tx_data), 32'h30);
        sync_reset = 1'b1;
        wr_en      = 1'b1;
        wr_data    = 8'h36;
        tick();
        sync_reset = 1'b0;
        wr_en      = 1'b0;
        check("t5_sr_count", 32'(fifo_count), 0);
        check("t5_sr_empty", 32'(fifo_empty), 1);
        check("t5_sr_busy", 32'(busy), 0);
        check("t5_sr_txdata", 32'(tx_data), 0);
        tick();
        tick();
        check("t5_sr_nostart", 32'(start_tx), 0);
        check("t5_sr_idle", 32'(busy), 0);
        man_active = 1'b0;
        tick();

        // Async reset in the middle of a start pulse
        wr_en   = 1'b1;
        wr_data = 8'h40;
        tick();
        wr_data = 8'h41;
        tick();
        wr_en = 1'b0;
        check("t5_ar_pre", 32'(start_tx), 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_ar_start", 32'(start_tx), 0);
        check("t5_ar_count", 32'(fifo_count), 0);
        check("t5_ar_busy", 32'(busy), 0);
        check("t5_ar_txdata", 32'(tx_data), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("t5_ar_after", 32'(busy), 0);

        // Test 6: random bursts against a scoreboard
        seen.delete();
        expq.delete();
        max_count = 0;
        auto_uart = 1'b1;
        guard     = 0;
        for (int b = 0; b < 20; b++) begin
            len = int'($urandom_range(1, 8));
            k   = 0;
            while (k < len && guard < 5000) begin
                if (!fifo_full) begin
                    wr_en   = 1'b1;
                    wr_data = 8'($urandom_range(0, 255));
                    expq.push_back(wr_data);
                    k++;
                end else begin
                    wr_en = 1'b0;
                end
                tick();
                guard++;
            end
            wr_en = 1'b0;
            gap   = int'($urandom_range(0, 12));
            repeat (gap) tick();
        end
        check("t6_push_budget", 32'(guard < 5000), 1);
        guard = 0;
        while (busy && guard < 2000) begin
            tick();
            guard++;
        end
        check("t6_drained", 32'(busy), 0);
        check("t6_nsent", 32'(seen.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            check("t6_order", 32'(seen[i]), 32'(expq[i]));
        end
        check("t6_maxcount", 32'(max_count <= 8), 1);
        check("t6_ovf", 32'(overflow), 0);
        check("single_cycle_start", 32'(dbl_start), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
